// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes, funct codes, ALU ops.
// Also holds the control-word struct that the top builds each cycle.
package mc_ctrl_pkg;

   localparam logic [2:0] StFetch  = 3'd0;
   localparam logic [2:0] StDecode = 3'd1;
   localparam logic [2:0] StExec   = 3'd2;
   localparam logic [2:0] StMem    = 3'd3;
   localparam logic [2:0] StWb     = 3'd4;

   localparam logic [5:0] OpRtype = 6'h00;
   localparam logic [5:0] OpLw    = 6'h23;
   localparam logic [5:0] OpSw    = 6'h2B;
   localparam logic [5:0] OpBeq   = 6'h04;
   localparam logic [5:0] OpAddi  = 6'h08;

   localparam logic [5:0] FnAdd = 6'h20;
   localparam logic [5:0] FnSub = 6'h22;
   localparam logic [5:0] FnAnd = 6'h24;
   localparam logic [5:0] FnOr  = 6'h25;
   localparam logic [5:0] FnSlt = 6'h2A;
   localparam logic [5:0] FnSll = 6'h00;
   localparam logic [5:0] FnSrl = 6'h02;

   localparam logic [4:0] AluAdd = 5'b00000;
   localparam logic [4:0] AluSub = 5'b00001;
   localparam logic [4:0] AluAnd = 5'b00010;
   localparam logic [4:0] AluOr  = 5'b00011;
   localparam logic [4:0] AluSlt = 5'b00100;
   localparam logic [4:0] AluSll = 5'b01000;
   localparam logic [4:0] AluSrl = 5'b01001;

   typedef struct packed {
      logic       pc_write;
      logic       pc_src;
      logic       ir_write;
      logic       i_or_d;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_a;
      logic       reg_b;
      logic       illegal_op;
      logic [1:0] alu_src_b;
      logic [4:0] alu_op;
   } ctrl_t;

   function automatic logic is_itype(input logic [5:0] op);
      return (op == OpLw) || (op == OpSw) || (op == OpBeq) || (op == OpAddi);
   endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// R-type funct decoder: maps Funct to an ALU op, flags shift ops (shamt on port B) and
// reports whether the funct is supported.
module mc_alu_decode
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] funct,
   output logic [4:0] alu_op,
   output logic       reg_b,
   output logic       valid
);

   always_comb begin
      alu_op = AluAdd;
      reg_b  = 1'b0;
      valid  = 1'b1;
      case (funct)
         FnAdd:   alu_op = AluAdd;
         FnSub:   alu_op = AluSub;
         FnAnd:   alu_op = AluAnd;
         FnOr:    alu_op = AluOr;
         FnSlt:   alu_op = AluSlt;
         FnSll: begin
            alu_op = AluSll;
            reg_b  = 1'b1;
         end
         FnSrl: begin
            alu_op = AluSrl;
            reg_b  = 1'b1;
         end
         default: valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control FSM (FETCH/DECODE/EXEC/MEM/WB) with combinational outputs.
// Define MC_CTRL_MEMWAIT_EN to stall FETCH and MEM until MemReady.
module mc_controller
   import mc_ctrl_pkg::*;
(
   input  logic       Clock,
   input  logic       Reset,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       PCSrc,
   output logic       IRWrite,
   output logic       IorD,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       MemtoReg,
   output logic       RegA,
   output logic       RegB,
   output logic       IllegalOp,
   output logic [1:0] ALUSrcB,
   output logic [4:0] ALUOp,
   output logic [2:0] State
);

   logic [2:0] state_q, state_d;
   logic       hold_q;
   logic       mem_ok;
   logic [4:0] dec_alu_op;
   logic       dec_reg_b;
   logic       dec_valid;
   logic       is_r, is_lw, is_sw, is_beq, is_addi, r_ok, legal;
   ctrl_t      ctrl;

`ifdef MC_CTRL_MEMWAIT_EN
   assign mem_ok = MemReady;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = MemReady;
   assign mem_ok = 1'b1;
`endif

   mc_alu_decode u_alu_decode (
      .funct  (Funct),
      .alu_op (dec_alu_op),
      .reg_b  (dec_reg_b),
      .valid  (dec_valid)
   );

   assign is_r    = (Op == OpRtype);
   assign is_lw   = (Op == OpLw);
   assign is_sw   = (Op == OpSw);
   assign is_beq  = (Op == OpBeq);
   assign is_addi = (Op == OpAddi);
   assign r_ok    = is_r & dec_valid;
   assign legal   = r_ok | is_itype(Op);

   // hold_q keeps the FSM parked, outputs quiet, until the first edge after reset release.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= StFetch;
         hold_q  <= 1'b1;
      end else if (hold_q) begin
         state_q <= StFetch;
         hold_q  <= 1'b0;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = StFetch;
      case (state_q)
         StFetch:  state_d = mem_ok ? StDecode : StFetch;
         StDecode: state_d = legal ? StExec : StFetch;
         StExec: begin
            if (is_lw || is_sw)        state_d = StMem;
            else if (r_ok || is_addi)  state_d = StWb;
            else                       state_d = StFetch;
         end
         StMem: begin
            if (!mem_ok)               state_d = StMem;
            else if (is_lw)            state_d = StWb;
            else                       state_d = StFetch;
         end
         StWb:     state_d = StFetch;
         default:  state_d = StFetch;
      endcase
   end

   always_comb begin
      ctrl = '0;
      case (state_q)
         StFetch: begin
            ctrl.mem_read  = 1'b1;
            ctrl.ir_write  = mem_ok;
            ctrl.pc_write  = mem_ok;
            ctrl.alu_src_b = 2'b01;
            ctrl.alu_op    = AluAdd;
         end
         StDecode: begin
            ctrl.alu_src_b  = 2'b11;
            ctrl.alu_op     = AluAdd;
            ctrl.illegal_op = ~legal;
         end
         StExec: begin
            ctrl.alu_src_a = 1'b1;
            if (is_r) begin
               ctrl.alu_op = dec_alu_op;
               ctrl.reg_b  = dec_reg_b;
            end else if (is_beq) begin
               ctrl.alu_op   = AluSub;
               ctrl.pc_src   = 1'b1;
               ctrl.pc_write = Zero;
            end else begin
               ctrl.alu_src_b = 2'b10;
               ctrl.alu_op    = AluAdd;
            end
         end
         StMem: begin
            ctrl.i_or_d    = 1'b1;
            ctrl.mem_read  = is_lw;
            ctrl.mem_write = is_sw;
         end
         StWb: begin
            ctrl.reg_write  = r_ok | is_addi | is_lw;
            ctrl.reg_dst    = is_r;
            ctrl.mem_to_reg = is_lw;
         end
         default: ctrl = '0;
      endcase
      if (Reset || hold_q) begin
         ctrl.pc_write   = 1'b0;
         ctrl.ir_write   = 1'b0;
         ctrl.reg_write  = 1'b0;
         ctrl.mem_write  = 1'b0;
         ctrl.mem_read   = 1'b0;
         ctrl.illegal_op = 1'b0;
      end
   end

   assign PCWrite   = ctrl.pc_write;
   assign PCSrc     = ctrl.pc_src;
   assign IRWrite   = ctrl.ir_write;
   assign IorD      = ctrl.i_or_d;
   assign RegDst    = ctrl.reg_dst;
   assign RegWrite  = ctrl.reg_write;
   assign ALUSrcA   = ctrl.alu_src_a;
   assign MemRead   = ctrl.mem_read;
   assign MemWrite  = ctrl.mem_write;
   assign MemtoReg  = ctrl.mem_to_reg;
   assign RegA      = ctrl.reg_a;
   assign RegB      = ctrl.reg_b;
   assign IllegalOp = ctrl.illegal_op;
   assign ALUSrcB   = ctrl.alu_src_b;
   assign ALUOp     = ctrl.alu_op;
   assign State     = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed table, reset corner cases and random
// instruction streams checked against an instruction-level cycle model.
module tb_mc_controller;

   logic       Clock = 1'b0;
   logic       Reset, Zero, MemReady;
   logic [5:0] Op, Funct;
   logic       PCWrite, PCSrc, IRWrite, IorD, RegDst, RegWrite, ALUSrcA;
   logic       MemRead, MemWrite, MemtoReg, RegA, RegB, IllegalOp;
   logic [1:0] ALUSrcB;
   logic [4:0] ALUOp;
   logic [2:0] State;

   mc_controller dut (
      .Clock(Clock), .Reset(Reset), .Op(Op), .Funct(Funct), .Zero(Zero),
      .MemReady(MemReady), .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite),
      .IorD(IorD), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegA(RegA),
      .RegB(RegB), .IllegalOp(IllegalOp), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .State(State)
   );

   always #5 Clock = ~Clock;

   typedef struct packed {
      logic [2:0] st;
      logic pcw, pcs, irw, iord, rdst, rw, asa, mrd, mwr, m2r, ra, rb, ill;
      logic [1:0] asb;
      logic [4:0] aop;
   } out_t;

   typedef struct {
      logic mr;
      out_t o;
   } cyc_t;

   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      logic       z;
      int         ncyc;
      logic [4:0] aop;
      logic       rb;
      logic       pcw;
   } vec_t;

   cyc_t exp_q[$];
   int   fetch_cycles;
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic out_t observe();
      return {State, PCWrite, PCSrc, IRWrite, IorD, RegDst, RegWrite, ALUSrcA, MemRead,
              MemWrite, MemtoReg, RegA, RegB, IllegalOp, ALUSrcB, ALUOp};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // {valid, shift, aluop} for each R-type funct
   function automatic logic [6:0] rinfo(input logic [5:0] f);
      case (f)
         6'h20: return {1'b1, 1'b0, 5'd0};
         6'h22: return {1'b1, 1'b0, 5'd1};
         6'h24: return {1'b1, 1'b0, 5'd2};
         6'h25: return {1'b1, 1'b0, 5'd3};
         6'h2A: return {1'b1, 1'b0, 5'd4};
         6'h00: return {1'b1, 1'b1, 5'd8};
         6'h02: return {1'b1, 1'b1, 5'd9};
         default: return 7'd0;
      endcase
   endfunction

   function automatic logic ready_bit();
`ifdef MC_CTRL_MEMWAIT_EN
      return 1'b1;
`else
      return 1'($urandom % 2);
`endif
   endfunction

   // Expand one instruction into the list of cycles it should occupy.
   task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                        input int wf_in, input int wm_in);
      cyc_t c;
      logic [6:0] info;
      logic rt, lw, sw, beq, addi, legal;
      int wf, wm;
      wf = wf_in;
      wm = wm_in;
`ifndef MC_CTRL_MEMWAIT_EN
      wf = 0;
      wm = 0;
`endif
      info = rinfo(fn);
      rt = (op == 6'h00); lw = (op == 6'h23); sw = (op == 6'h2B);
      beq = (op == 6'h04); addi = (op == 6'h08);
      legal = (rt && info[6]) || lw || sw || beq || addi;
      exp_q.delete();
      for (int w = 0; w < wf; w++) begin
         c.o = '0; c.o.mrd = 1; c.o.asb = 2'b01; c.mr = 0;
         exp_q.push_back(c);
      end
      c.o = '0; c.o.mrd = 1; c.o.asb = 2'b01; c.o.pcw = 1; c.o.irw = 1;
      c.mr = (wf > 0) ? 1'b1 : ready_bit();
      exp_q.push_back(c);
      fetch_cycles = wf + 1;
      c.o = '0; c.o.st = 1; c.o.asb = 2'b11; c.o.ill = !legal; c.mr = 1'($urandom % 2);
      exp_q.push_back(c);
      if (!legal) return;
      c.o = '0; c.o.st = 2; c.o.asa = 1; c.mr = 1'($urandom % 2);
      if (rt) begin
         c.o.aop = info[4:0]; c.o.rb = info[5];
      end else if (beq) begin
         c.o.aop = 5'd1; c.o.pcs = 1; c.o.pcw = z;
      end else begin
         c.o.asb = 2'b10;
      end
      exp_q.push_back(c);
      if (lw || sw) begin
         c.o = '0; c.o.st = 3; c.o.iord = 1; c.o.mrd = lw; c.o.mwr = sw;
         for (int w = 0; w < wm; w++) begin
            c.mr = 0;
            exp_q.push_back(c);
         end
         c.mr = (wm > 0) ? 1'b1 : ready_bit();
         exp_q.push_back(c);
      end
      if (rt || addi || lw) begin
         c.o = '0; c.o.st = 4; c.o.rw = 1; c.o.rdst = rt; c.o.m2r = lw;
         c.mr = 1'($urandom % 2);
         exp_q.push_back(c);
      end
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      #2;
      check("rst_state", 32'(State), 0);
      check("rst_gate", {PCWrite, IRWrite, RegWrite, MemWrite, MemRead, IllegalOp}, 0);
      @(posedge Clock);
      @(posedge Clock);
      #1 Reset = 1'b0;
      @(negedge Clock);
      check("hold_state", 32'(State), 0);
      check("hold_gate", {PCWrite, IRWrite, MemRead}, 0);
      @(posedge Clock);
      #1;
   endtask

   // Entered and left at posedge+1 with the DUT in a fresh FETCH.
   task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input int wf, input int wm, output int ncyc, output out_t ex);
      out_t act;
      bit done;
      build(op, fn, z, wf, wm);
      Op = op; Funct = fn; Zero = z;
      ncyc = 0; ex = '0; done = 0;
      for (int i = 0; i < 16; i++) begin
         MemReady = (i < exp_q.size()) ? exp_q[i].mr : 1'b1;
         @(negedge Clock);
         act = observe();
         if (i < exp_q.size()) check("cycle", 32'(act), 32'(exp_q[i].o));
         else check("overrun_state", 32'(act.st), 0);
         if (act.st == 3'd2) ex = act;
         ncyc++;
         @(posedge Clock);
         #1;
         if (State == 3'd0 && ncyc >= fetch_cycles) begin
            done = 1;
            break;
         end
      end
      check("length", 32'(ncyc), 32'(exp_q.size()));
      if (!done) begin
         check("timeout", 0, 1);
         do_reset();
      end
   endtask

   vec_t tbl[14];

   initial begin
      int   n;
      out_t ex;
      logic [5:0] op, fn;
      int   sel;

      tbl[0]  = '{6'h00, 6'h20, 0, 4, 5'd0, 0, 0};
      tbl[1]  = '{6'h00, 6'h22, 0, 4, 5'd1, 0, 0};
      tbl[2]  = '{6'h00, 6'h24, 0, 4, 5'd2, 0, 0};
      tbl[3]  = '{6'h00, 6'h25, 1, 4, 5'd3, 0, 0};
      tbl[4]  = '{6'h00, 6'h2A, 0, 4, 5'd4, 0, 0};
      tbl[5]  = '{6'h00, 6'h00, 0, 4, 5'd8, 1, 0};
      tbl[6]  = '{6'h00, 6'h02, 1, 4, 5'd9, 1, 0};
      tbl[7]  = '{6'h23, 6'h11, 0, 5, 5'd0, 0, 0};
      tbl[8]  = '{6'h2B, 6'h00, 0, 4, 5'd0, 0, 0};
      tbl[9]  = '{6'h04, 6'h00, 1, 3, 5'd1, 0, 1};
      tbl[10] = '{6'h04, 6'h00, 0, 3, 5'd1, 0, 0};
      tbl[11] = '{6'h08, 6'h3F, 0, 4, 5'd0, 0, 0};
      tbl[12] = '{6'h3F, 6'h20, 0, 2, 5'd0, 0, 0};
      tbl[13] = '{6'h00, 6'h3F, 0, 2, 5'd0, 0, 0};

      Op = 0; Funct = 0; Zero = 0; MemReady = 1;
      do_reset();

      for (int i = 0; i < 14; i++) begin
         run(tbl[i].op, tbl[i].fn, tbl[i].z, 0, 0, n, ex);
         check($sformatf("tbl%0d_cycles", i), 32'(n), 32'(tbl[i].ncyc));
         check($sformatf("tbl%0d_aluop", i), 32'(ex.aop), 32'(tbl[i].aop));
         check($sformatf("tbl%0d_regb", i), 32'(ex.rb), 32'(tbl[i].rb));
         check($sformatf("tbl%0d_pcwrite", i), 32'(ex.pcw), 32'(tbl[i].pcw));
      end

      // Reset pulsed mid-EXEC of LW, released before the next edge.
      Op = 6'h23; Funct = 0; MemReady = 1;
      @(posedge Clock); #1;
      @(posedge Clock); #1;
      check("lw_in_exec", 32'(State), 2);
      #2 Reset = 1'b1;
      #1;
      check("lw_abort_state", 32'(State), 0);
      check("lw_abort_gate", {MemRead, RegWrite, MemWrite, PCWrite, IRWrite}, 0);
      #1 Reset = 1'b0;
      #2;
      check("lw_abort_hold", {State, MemRead, RegWrite}, 0);
      @(posedge Clock); #1;
      run(6'h23, 6'h00, 0, 0, 0, n, ex);
      check("lw_after_reset_cycles", 32'(n), 5);

      // Reset during MEM of SW, held across an edge.
      Op = 6'h2B; MemReady = 1;
      @(posedge Clock); #1;
      @(posedge Clock); #1;
      @(posedge Clock); #1;
      check("sw_in_mem", {State, MemWrite, IorD}, {3'd3, 2'b11});
      #2 Reset = 1'b1;
      #1;
      check("sw_abort", {State, MemWrite, MemRead}, 0);
      @(posedge Clock); #1;
      check("sw_reset_held", {State, PCWrite, IRWrite, RegWrite, MemWrite, MemRead}, 0);
      Reset = 1'b0;
      @(posedge Clock); #1;
      run(6'h00, 6'h20, 0, 0, 0, n, ex);
      check("add_after_sw_reset", 32'(n), 4);

`ifdef MC_CTRL_MEMWAIT_EN
      run(6'h2B, 6'h00, 0, 0, 3, n, ex);
      check("sw_memwait_cycles", 32'(n), 7);
      run(6'h00, 6'h24, 0, 2, 0, n, ex);
      check("fetch_wait_cycles", 32'(n), 6);
      run(6'h23, 6'h00, 0, 1, 2, n, ex);
      check("lw_wait_cycles", 32'(n), 8);
`else
      run(6'h2B, 6'h00, 0, 3, 3, n, ex);
      check("sw_nowait_cycles", 32'(n), 4);
`endif

      for (int k = 0; k < 300; k++) begin
         sel = $urandom % 8;
         fn = ($urandom % 5 != 0) ? rinfo_pick() : 6'($urandom);
         case (sel)
            0, 1: op = 6'h00;
            2: op = 6'h23;
            3: op = 6'h2B;
            4: op = 6'h04;
            5: op = 6'h08;
            6: op = 6'($urandom);
            default: op = 6'h3F;
         endcase
         run(op, fn, 1'($urandom % 2), int'($urandom % 3), int'($urandom % 4), n, ex);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   function automatic logic [5:0] rinfo_pick();
      logic [5:0] fns [7];
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};
      return fns[$urandom % 7];
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

endmodule
